// File: rtl/mem_line_reader.sv
// mem_line_reader
//   Reads a run of 32-byte lines from main memory and streams them out one
//   byte per handshake, tagging each byte with its own byte address.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle request, accepted only in IDLE
//   start_addr        : first line byte address (offset bits ignored)
//   num_lines         : number of lines to read (0 completes immediately)
//   busy              : high while requesting or sending
//   done              : one-cycle completion pulse
//   mem_rd_req/addr   : line read request and line-aligned address
//   mem_rd_ack/data   : memory returns the full line on ack
//   out_valid/data/addr/out_ready : byte stream with its byte address
//   fsm_state         : debug view of the controller state
//
// Handshake rules: a memory request is held with a stable address until
// mem_rd_ack is seen in REQ; ack at any other time is ignored. An output byte
// transfers on a cycle where out_valid and out_ready are both high; while
// out_ready is low, out_data and out_addr hold their values.
module mem_line_reader #(
    parameter int ADDR_W     = 15,
    parameter int LINE_BYTES = 32,
    parameter int CNT_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [CNT_W-1:0]        num_lines,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_req,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic                    mem_rd_ack,
    input  logic [8*LINE_BYTES-1:0] mem_rd_data,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    output logic [ADDR_W-1:0]       out_addr,
    input  logic                    out_ready,
    output logic [1:0]              fsm_state
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]              state;
    logic [ADDR_W-1:0]       line_addr;
    logic [CNT_W-1:0]        lines_left;
    logic [OFF_W-1:0]        idx;
    logic [8*LINE_BYTES-1:0] line_buf;
    logic                    last_byte;

    assign last_byte = (idx == OFF_W'(LINE_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            line_addr  <= '0;
            lines_left <= '0;
            idx        <= '0;
            line_buf   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Offset bits are dropped so every request is line aligned.
                        line_addr  <= start_addr & ~ADDR_W'(LINE_BYTES - 1);
                        lines_left <= num_lines;
                        state      <= (num_lines != '0) ? S_REQ : S_FIN;
                    end
                end
                S_REQ: begin
                    if (mem_rd_ack) begin
                        line_buf <= mem_rd_data;
                        idx      <= '0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        idx <= idx + OFF_W'(1);
                        if (last_byte) begin
                            lines_left <= lines_left - CNT_W'(1);
                            // Natural overflow gives the wrap at the top of memory.
                            line_addr  <= line_addr + ADDR_W'(LINE_BYTES);
                            state      <= (lines_left != CNT_W'(1)) ? S_REQ : S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign fsm_state   = state;
    assign busy        = (state == S_REQ) || (state == S_SEND);
    assign done        = (state == S_FIN);
    assign mem_rd_req  = (state == S_REQ);
    assign mem_rd_addr = (state == S_REQ) ? line_addr : '0;
    assign out_valid   = (state == S_SEND);
    assign out_data    = (state == S_SEND) ? line_buf[{idx, 3'b000} +: 8] : 8'h00;
    assign out_addr    = (state == S_SEND) ? (line_addr + ADDR_W'(idx)) : '0;

endmodule

// File: tb/tb_mem_line_reader.sv
// Directed bench for mem_line_reader: a small memory model answers line
// requests, and every delivered byte is checked against an expected queue of
// byte addresses whose data comes from a fixed address-to-byte function.
module tb_mem_line_reader;

    localparam int ADDR_W     = 15;
    localparam int LINE_BYTES = 32;
    localparam int CNT_W      = 10;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       start_addr = '0;
    logic [CNT_W-1:0]        num_lines = '0;
    logic                    busy;
    logic                    done;
    logic                    mem_rd_req;
    logic [ADDR_W-1:0]       mem_rd_addr;
    logic                    mem_rd_ack = 1'b0;
    logic [8*LINE_BYTES-1:0] mem_rd_data = '0;
    logic                    out_valid;
    logic [7:0]              out_data;
    logic [ADDR_W-1:0]       out_addr;
    logic                    out_ready = 1'b0;
    logic [1:0]              fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] line_q[$];

    mem_line_reader #(
        .ADDR_W    (ADDR_W),
        .LINE_BYTES(LINE_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .num_lines  (num_lines),
        .busy       (busy),
        .done       (done),
        .mem_rd_req (mem_rd_req),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack (mem_rd_ack),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_ready  (out_ready),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory contents ----------------
    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    function automatic logic [8*LINE_BYTES-1:0] line_data(input logic [ADDR_W-1:0] base);
        logic [8*LINE_BYTES-1:0] d;
        d = '0;
        for (int i = 0; i < LINE_BYTES; i++) d[8*i +: 8] = mem_byte(base + ADDR_W'(i));
        return d;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_done"},        done,        0);
        check({tag, "_mem_rd_req"},  mem_rd_req,  0);
        check({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
        check({tag, "_out_valid"},   out_valid,   0);
        check({tag, "_out_data"},    out_data,    0);
        check({tag, "_out_addr"},    out_addr,    0);
        check({tag, "_state"},       fsm_state,   0);
    endtask

    // ---------------- driver + scoreboard ----------------
    // rand_ready: random out_ready, stray acks, and an extra start while busy.
    // reset_at  : byte count at which reset is pulsed mid-stream (-1 = never).
    task automatic run_transfer(input logic [ADDR_W-1:0] sa, input logic [CNT_W-1:0] nl,
                                input int ack_dly, input bit rand_ready, input int reset_at);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] req_addr;
        logic [ADDR_W-1:0] hold_addr;
        logic [ADDR_W-1:0] a;
        logic [7:0]        hold_data;
        int                cyc;
        int                req_wait;
        int                sent;
        bit                stalled;
        bit                finished;

        exp_q.delete();
        line_q.delete();
        base = sa & 15'h7FE0;
        for (int l = 0; l < int'(nl); l++) begin
            line_q.push_back(base);
            for (int b = 0; b < LINE_BYTES; b++) exp_q.push_back(base + ADDR_W'(b));
            base = base + ADDR_W'(LINE_BYTES);
        end

        @(negedge clk);
        start = 1'b1; start_addr = sa; num_lines = nl;

        cyc = 0; req_wait = 0; sent = 0; stalled = 0; finished = 0;
        req_addr = '0; hold_addr = '0; hold_data = '0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0; mem_rd_ack = 1'b0; out_ready = 1'b0;
            cyc++;
            if (rand_ready && cyc == 6) begin
                start = 1'b1; start_addr = 15'h1234; num_lines = 10'd7;
            end
            if (done) begin
                check("busy_at_done", busy, 0);
                check("lines_left_at_done", line_q.size(), 0);
                check("bytes_left_at_done", exp_q.size(), 0);
                if (!rand_ready) check("cycles_to_done", cyc, int'(nl) * (ack_dly + 33) + 1);
                start = 1'b1; start_addr = 15'h0100; num_lines = 10'd3;
                @(negedge clk);
                start = 1'b0;
                check("done_width", done, 0);
                check("idle_after_fin", fsm_state, 0);
                check("start_in_fin_ignored", mem_rd_req, 0);
                finished = 1;
            end else begin
                check("busy", busy, 1);
                if (mem_rd_req) begin
                    check("no_valid_in_req", out_valid, 0);
                    if (req_wait == 0) begin
                        if (line_q.size() == 0) begin
                            check("unexpected_req", 1, 0);
                            req_addr = '0;
                        end else begin
                            req_addr = line_q.pop_front();
                        end
                    end
                    check("mem_rd_addr", mem_rd_addr, req_addr);
                    if (req_wait == ack_dly) begin
                        mem_rd_ack  = 1'b1;
                        mem_rd_data = line_data(req_addr);
                    end
                    req_wait++;
                end else begin
                    req_wait = 0;
                    if (rand_ready) begin
                        mem_rd_ack  = 1'($urandom_range(0, 1));
                        mem_rd_data = {8{$urandom()}};
                    end
                end
                if (out_valid) begin
                    if (stalled) begin
                        check("stall_addr_stable", out_addr, hold_addr);
                        check("stall_data_stable", out_data, hold_data);
                    end
                    if (reset_at >= 0 && sent == reset_at) begin
                        rst_n = 1'b0;
                        #1;
                        check_all_zero("reset_mid_send");
                        repeat (3) begin
                            @(negedge clk);
                            check("no_done_in_reset", done, 0);
                        end
                        rst_n = 1'b1;
                        @(negedge clk);
                        check("idle_after_abort", fsm_state, 0);
                        check("no_done_after_abort", done, 0);
                        finished = 1;
                    end else begin
                        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                        if (out_ready) begin
                            if (exp_q.size() == 0) begin
                                check("unexpected_byte", 1, 0);
                            end else begin
                                a = exp_q.pop_front();
                                check("out_addr", out_addr, a);
                                check("out_data", out_data, mem_byte(a));
                            end
                            sent++;
                            stalled = 0;
                        end else begin
                            stalled   = 1;
                            hold_addr = out_addr;
                            hold_data = out_data;
                        end
                    end
                end else begin
                    stalled = 0;
                end
            end
        end
        mem_rd_ack = 1'b0;
        out_ready  = 1'b0;
        start      = 1'b0;
        if (!finished) begin
            check("timeout", 1, 0);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", fsm_state, 0);
        check("busy_after_release", busy, 0);

        run_transfer(15'h0040, 10'd1, 3, 1'b0, -1);  // single line, ack after 3
        run_transfer(15'h0000, 10'd0, 0, 1'b0, -1);  // zero lines
        run_transfer(15'h7FE5, 10'd2, 0, 1'b0, -1);  // wrap at top of memory
        run_transfer(15'h1234, 10'd3, 2, 1'b1, -1);  // random stalls, extra start
        run_transfer(15'h0200, 10'd2, 1, 1'b0, 42);  // reset at line 2, byte 10
        run_transfer(15'h0300, 10'd1, 0, 1'b0, -1);  // normal after reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
